// File: rtl/ok_wire_out_bank_pkg.sv
// Shared definitions for the Wire Out endpoint bank: FSM encoding, host address window,
// output timing constant and a configuration range check.
package ok_wire_out_bank_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } wo_state_e;

    // Wire Out endpoints occupy this address window on the host interface.
    localparam int unsigned WO_ADDR_MIN = 32'h20;
    localparam int unsigned WO_ADDR_MAX = 32'h3F;
    localparam int unsigned WO_MAX_EP   = 32;

    // Output assignment delay in ns for simulation-side sampling.
    localparam int unsigned TDOUT_DELAY = 1;

    function automatic bit wo_range_ok(input int unsigned base, input int unsigned num);
        return (num >= 1) && (num <= WO_MAX_EP) &&
               (base >= WO_ADDR_MIN) && (base + num - 1 <= WO_ADDR_MAX);
    endfunction

endpackage

// File: rtl/ok_wire_out_capture.sv
// One Wire Out endpoint: optional OR-accumulator, snapshot register taken on a capture
// strobe, and a flag telling whether the latest snapshot differs from the previous one.
module ok_wire_out_capture #(
    parameter bit STICKY = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        capture_i,
    input  logic [31:0] data_i,
    output logic [31:0] snap_o,
    output logic        changed_o
);

    logic [31:0] sample;
    logic [31:0] snap_q, snap_d;
    logic        changed_q, changed_d;

    if (STICKY) begin : g_sticky
        logic [31:0] acc_q;

        // Capture edge folds in the current input and restarts accumulation from zero.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                acc_q <= '0;
            end else if (capture_i) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_q | data_i;
            end
        end

        assign sample = acc_q | data_i;
    end else begin : g_plain
        // A plain endpoint's accumulator is just the current input word.
        assign sample = data_i;
    end

    always_comb begin
        snap_d    = snap_q;
        changed_d = changed_q;
        if (capture_i) begin
            snap_d    = sample;
            changed_d = (sample != snap_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snap_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            snap_q    <= snap_d;
            changed_q <= changed_d;
        end
    end

    assign snap_o    = snap_q;
    assign changed_o = changed_q;

endmodule

// File: rtl/ok_wire_out_bank.sv
// Bank of host-bound Wire Out endpoints: snapshots all endpoints on a wire update and
// streams the snapshot one word per valid/ready handshake, tagged with its address.
module ok_wire_out_bank
    import ok_wire_out_bank_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'h20,
    parameter int unsigned NUM_EP      = 4,
    parameter logic [31:0] STICKY_MASK = 32'h0
) (
    input  logic                  ti_clk,
    input  logic                  ti_reset,
    input  logic                  ti_wireupdate,
    input  logic [NUM_EP*32-1:0]  ep_datain,
    output logic [31:0]           ti_dataout,
    output logic [7:0]            ti_dataout_addr,
    output logic                  ti_dataout_valid,
    input  logic                  ti_dataout_ready,
    output logic                  ti_stream_done,
    output logic [NUM_EP-1:0]     ep_changed,
    output logic [15:0]           update_count,
    output logic                  update_overrun
);

    if (!wo_range_ok({24'h0, BASE_ADDR}, NUM_EP)) begin : g_bad_cfg
        $error("ok_wire_out_bank: endpoint range outside 0x20..0x3F or NUM_EP not in 1..32");
    end

    localparam logic [4:0] LAST_IDX = 5'(NUM_EP - 1);

    wo_state_e   state_q;
    logic [4:0]  idx_q;
    logic        valid_q;
    logic        done_q;
    logic [15:0] count_q;
    logic        overrun_q;

    logic                 capture;
    logic [NUM_EP*32-1:0] snap_flat;
    logic [31:0]          word;

    // Snapshots are only taken from IDLE; updates in other states only raise overrun.
    assign capture = (state_q == StIdle) && ti_wireupdate;

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        ok_wire_out_capture #(
            .STICKY (STICKY_MASK[i])
        ) u_capture (
            .clk_i     (ti_clk),
            .reset_i   (ti_reset),
            .capture_i (capture),
            .data_i    (ep_datain[32*i +: 32]),
            .snap_o    (snap_flat[32*i +: 32]),
            .changed_o (ep_changed[i])
        );
    end

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            if (idx_q == 5'(i)) begin
                word = snap_flat[32*i +: 32];
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ti_wireupdate) begin
                        count_q <= count_q + 16'd1;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (ti_wireupdate) begin
                        overrun_q <= 1'b1;
                    end
                    if (ti_dataout_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    if (ti_wireupdate) begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Data and address are forced to zero whenever no word is presented.
    assign ti_dataout       = valid_q ? word : '0;
    assign ti_dataout_addr  = valid_q ? (BASE_ADDR + {3'b000, idx_q}) : '0;
    assign ti_dataout_valid = valid_q;
    assign ti_stream_done   = done_q;
    assign update_count     = count_q;
    assign update_overrun   = overrun_q;

endmodule

// File: tb/tb_ok_wire_out_bank.sv
// Directed bench for ok_wire_out_bank: table-driven stream vectors plus hand-written
// sequences for reset mid-stream and sticky accumulation.
module tb_ok_wire_out_bank;
    import ok_wire_out_bank_pkg::*;

    logic         ti_clk = 1'b0;
    logic         ti_reset;
    logic         ti_wireupdate;
    logic [127:0] ep_datain;
    logic [31:0]  ti_dataout;
    logic [7:0]   ti_dataout_addr;
    logic         ti_dataout_valid;
    logic         ti_dataout_ready;
    logic         ti_stream_done;
    logic [3:0]   ep_changed;
    logic [15:0]  update_count;
    logic         update_overrun;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    ok_wire_out_bank #(
        .BASE_ADDR   (8'h20),
        .NUM_EP      (4),
        .STICKY_MASK (32'h1)
    ) dut (
        .ti_clk           (ti_clk),
        .ti_reset         (ti_reset),
        .ti_wireupdate    (ti_wireupdate),
        .ep_datain        (ep_datain),
        .ti_dataout       (ti_dataout),
        .ti_dataout_addr  (ti_dataout_addr),
        .ti_dataout_valid (ti_dataout_valid),
        .ti_dataout_ready (ti_dataout_ready),
        .ti_stream_done   (ti_stream_done),
        .ep_changed       (ep_changed),
        .update_count     (update_count),
        .update_overrun   (update_overrun)
    );

    always #5 ti_clk = ~ti_clk;

    typedef struct {
        logic        wu;
        logic        rdy;
        logic        valid;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        done;
    } row_t;

    row_t rows[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ti_clk);
        #(TDOUT_DELAY);
    endtask

    task automatic apply_row(input int i);
        ti_wireupdate    = rows[i].wu;
        ti_dataout_ready = rows[i].rdy;
        step();
        check($sformatf("row%0d valid", i), 32'(ti_dataout_valid), 32'(rows[i].valid));
        check($sformatf("row%0d addr", i), 32'(ti_dataout_addr), 32'(rows[i].addr));
        check($sformatf("row%0d data", i), ti_dataout, rows[i].data);
        check($sformatf("row%0d done", i), 32'(ti_stream_done), 32'(rows[i].done));
    endtask

    // Hold ready high until the done pulse; a missing pulse within the budget is a failure.
    task automatic drain(input string name);
        bit seen;
        seen             = 1'b0;
        ti_wireupdate    = 1'b0;
        ti_dataout_ready = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (ti_stream_done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;

        //            wu    rdy   valid addr   data   done
        rows[0]  = '{1'b1, 1'b1, 1'b1, 8'h20, 32'd1, 1'b0};
        rows[1]  = '{1'b0, 1'b1, 1'b1, 8'h21, 32'd2, 1'b0};
        rows[2]  = '{1'b0, 1'b1, 1'b1, 8'h22, 32'd3, 1'b0};
        rows[3]  = '{1'b0, 1'b1, 1'b1, 8'h23, 32'd4, 1'b0};
        rows[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 32'd0, 1'b1};
        rows[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 32'd0, 1'b0};
        rows[6]  = '{1'b1, 1'b1, 1'b1, 8'h20, 32'd1, 1'b0};
        rows[7]  = '{1'b0, 1'b1, 1'b1, 8'h21, 32'd2, 1'b0};
        rows[8]  = '{1'b0, 1'b0, 1'b1, 8'h21, 32'd2, 1'b0};
        rows[9]  = '{1'b0, 1'b0, 1'b1, 8'h21, 32'd2, 1'b0};
        rows[10] = '{1'b0, 1'b1, 1'b1, 8'h22, 32'd3, 1'b0};
        rows[11] = '{1'b1, 1'b0, 1'b1, 8'h22, 32'd3, 1'b0};
        rows[12] = '{1'b0, 1'b1, 1'b1, 8'h23, 32'd4, 1'b0};
        rows[13] = '{1'b0, 1'b0, 1'b1, 8'h23, 32'd4, 1'b0};
        rows[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 32'd0, 1'b1};
        rows[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 32'd0, 1'b0};
        rows[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 32'd0, 1'b0};

        // Reset and idle
        ti_reset         = 1'b1;
        ti_wireupdate    = 1'b0;
        ti_dataout_ready = 1'b0;
        ep_datain        = '0;
        repeat (3) step();
        ti_reset = 1'b0;
        repeat (10) step();
        check("idle valid", 32'(ti_dataout_valid), 32'd0);
        check("idle data", ti_dataout, 32'd0);
        check("idle addr", 32'(ti_dataout_addr), 32'd0);
        check("idle done", 32'(ti_stream_done), 32'd0);
        check("idle changed", 32'(ep_changed), 32'd0);
        check("idle count", 32'(update_count), 32'd0);
        check("idle overrun", 32'(update_overrun), 32'd0);

        // Full-rate stream, then back-pressured stream with overrun and a DONE-state update
        ep_datain = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i <= 5; i++) apply_row(i);
        check("first count", 32'(update_count), 32'd1);
        check("first changed", 32'(ep_changed), 32'hF);
        check("first overrun", 32'(update_overrun), 32'd0);
        for (int i = 6; i <= 16; i++) apply_row(i);
        check("second count", 32'(update_count), 32'd2);
        check("second changed", 32'(ep_changed), 32'h0);
        check("second overrun", 32'(update_overrun), 32'd1);

        // Reset while word 0x21 is presented
        ti_wireupdate    = 1'b1;
        ti_dataout_ready = 1'b0;
        step();
        ti_wireupdate = 1'b0;
        check("pre-reset addr0", 32'(ti_dataout_addr), 32'h20);
        ti_dataout_ready = 1'b1;
        step();
        check("pre-reset addr1", 32'(ti_dataout_addr), 32'h21);
        ti_reset         = 1'b1;
        ti_dataout_ready = 1'b0;
        step();
        ti_reset = 1'b0;
        check("rst valid", 32'(ti_dataout_valid), 32'd0);
        check("rst done", 32'(ti_stream_done), 32'd0);
        check("rst count", 32'(update_count), 32'd0);
        check("rst overrun", 32'(update_overrun), 32'd0);
        check("rst changed", 32'(ep_changed), 32'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ti_stream_done || ti_dataout_valid) done_seen = 1'b1;
        end
        check("rst no done", 32'(done_seen), 32'd0);
        ti_wireupdate = 1'b1;
        step();
        ti_wireupdate = 1'b0;
        check("post-rst valid", 32'(ti_dataout_valid), 32'd1);
        check("post-rst addr", 32'(ti_dataout_addr), 32'h20);
        check("post-rst data", ti_dataout, 32'd1);
        check("post-rst count", 32'(update_count), 32'd1);
        check("post-rst changed", 32'(ep_changed), 32'hF);
        drain("post-rst drain");

        // Sticky accumulation on endpoint 0
        ti_reset  = 1'b1;
        ep_datain = '0;
        repeat (2) step();
        ti_reset = 1'b0;
        step();
        ep_datain[31:0] = 32'h1;
        step();
        ep_datain[31:0] = 32'h4;
        step();
        ep_datain[31:0] = 32'h0;
        step();
        ti_wireupdate    = 1'b1;
        ti_dataout_ready = 1'b0;
        step();
        ti_wireupdate = 1'b0;
        check("sticky addr", 32'(ti_dataout_addr), 32'h20);
        check("sticky data", ti_dataout, 32'h5);
        check("sticky changed", 32'(ep_changed), 32'h1);
        ti_dataout_ready = 1'b1;
        step();
        check("sticky ep1 addr", 32'(ti_dataout_addr), 32'h21);
        check("sticky ep1 data", ti_dataout, 32'h0);
        drain("sticky drain1");
        step();
        ti_wireupdate    = 1'b1;
        ti_dataout_ready = 1'b0;
        step();
        ti_wireupdate = 1'b0;
        check("sticky2 addr", 32'(ti_dataout_addr), 32'h20);
        check("sticky2 data", ti_dataout, 32'h0);
        check("sticky2 changed", 32'(ep_changed), 32'h1);
        check("sticky2 count", 32'(update_count), 32'd2);
        drain("sticky drain2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ok_wire_out_bank.md
Name: ok_wire_out_bank

Overview:
- Simulation model of a bank of host-bound "Wire Out" endpoints at contiguous addresses.
- Each cycle the bank samples user-side 32-bit words, optionally OR-accumulating them.
- On a host wire-update it snapshots all endpoints and streams the snapshot to the host side one word per accepted handshake, tagged with the endpoint address.
- It is the device-to-host counterpart of the Wire In path and sits beside it on the same ti_clk host-interface domain.

Parameters:
- BASE_ADDR, 8'h20, address of endpoint 0; endpoint i is at BASE_ADDR+i.
- NUM_EP, 4, number of endpoints, 1..32.
- STICKY_MASK, 32'h0, bit i=1 makes endpoint i OR-accumulate between updates; bit i=0 samples plainly.
- TDOUT_DELAY, from the shared timing constants, output assignment delay in ns (simulation only).

Ports:
- ti_clk  input  1  host-interface clock; all logic on rising edge.
- ti_reset  input  1  synchronous, active-high reset.
- ti_wireupdate  input  1  one-cycle host request to snapshot and stream.
- ep_datain  input  NUM_EP*32  user words; endpoint i is bits [32i+31:32i].
- ti_dataout  output  32  streamed snapshot word.
- ti_dataout_addr  output  8  endpoint address of ti_dataout.
- ti_dataout_valid  output  1  word present.
- ti_dataout_ready  input  1  host accepts the word on the edge where valid&ready.
- ti_stream_done  output  1  one-cycle pulse after the last word is accepted.
- ep_changed  output  NUM_EP  bit i=1 if endpoint i's latest snapshot differs from its previous one.
- update_count  output  16  number of accepted updates, wraps at 16'hFFFF->0.
- update_overrun  output  1  sticky flag: a wireupdate arrived while not IDLE.

Behaviour:
- Reset wins over every other event on the same edge.
  - All outputs go to 0: ti_dataout, addr, valid, done, ep_changed, update_count, update_overrun.
  - Snapshots and accumulators are cleared; FSM goes to IDLE.
  - Reset mid-stream aborts the stream; no done pulse is produced.
- Accumulator, sticky endpoints: every edge acc_i <= acc_i | ep_datain_i.
- Accumulator, plain endpoints: acc_i <= ep_datain_i.
- FSM has three states: IDLE, STREAM, DONE.
- IDLE with ti_wireupdate=1 at edge k:
  - snap_i <= sticky ? (acc_i | ep_datain_i) : ep_datain_i. The edge-k input is always included.
  - Sticky acc_i <= 0.
  - ep_changed_i <= (new snap_i != old snap_i).
  - update_count += 1.
  - idx <= 0; state <= STREAM.
- STREAM:
  - After edge k: ti_dataout_valid=1, ti_dataout=snap_idx, ti_dataout_addr=BASE_ADDR+idx.
  - Zero-cycle latency from the snapshot edge.
  - On a valid&ready edge with idx<NUM_EP-1: idx += 1 and the next word is presented immediately.
  - On a valid&ready edge with idx=NUM_EP-1: valid <= 0, state <= DONE.
  - With ready low, data and addr hold stable and valid stays high.
- DONE: ti_stream_done=1 for exactly one cycle, then IDLE.
- ti_wireupdate in STREAM or DONE is ignored: no snapshot, no count. update_overrun <= 1 and holds until reset.
- When not valid, ti_dataout and ti_dataout_addr are driven to 0 (wire-OR-safe).
- Elaboration check: the range BASE_ADDR..BASE_ADDR+NUM_EP-1 must lie within 0x20..0x3F, and NUM_EP must be in 1..32. Otherwise $error then $finish.
- Register outputs are assigned with #TDOUT_DELAY.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (IDLE/STREAM/DONE).
  - Wire Out address limits 0x20/0x3F.
  - TDOUT_DELAY.
- Sub-module ok_wire_out_capture is instantiated NUM_EP times via generate.
  - It contains the per-endpoint accumulator, snapshot register and change detection.
  - Parameter: STICKY. Inputs: capture strobe, data. Outputs: snapshot, changed.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, no valid.
- NUM_EP=4, ep_datain={4,3,2,1}, wireupdate, ready held 1 -> 4 consecutive valid cycles:
  - (0x20,1), (0x21,2), (0x22,3), (0x23,4).
  - done pulses on the next cycle; update_count=1; ep_changed=4'b1111.
- Ready toggled 1,0,0,1,... -> each word stays stable while ready=0; no word is skipped or duplicated; done only after 0x23 is accepted.
- STICKY_MASK=1: pulse ep_datain[0] with 0x1, then 0x4, then 0, then wireupdate -> word 0x20 = 0x5. A second update with input 0 -> 0x0 and ep_changed[0]=1.
- Wireupdate asserted during STREAM -> stream unaffected; update_count unchanged; update_overrun=1.
- ti_reset while streaming word 0x21 -> valid=0 on the next cycle, no done pulse, update_count=0. A following update streams from 0x20.
